// File: rtl/pe_wb_arbiter.sv
// pe_wb_arbiter: register-file write-port arbiter for three sources (EX, LSU load
// return, COM). EX wins whenever it is not stalled; LD and CM share the leftover
// cycles round-robin. A starvation counter inserts a one-cycle EX bubble so that a
// waiting secondary source always gets in. The RF write is registered one cycle
// after the grant.
// Optional build macro PE_WB_ARB_STATS_EN adds a saturating 16-bit
// conflict-cycle counter on oArb_Conflict_Count.
module pe_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int RF_IDX_W     = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iEX_Write_RF_Enable,
    input  logic [RF_IDX_W-1:0] iEX_Write_RF_Address,
    input  logic [DATA_W-1:0]   iEX_Write_RF_Data,
    output logic                oEX_Stall,
    input  logic                iLD_Valid,
    output logic                oLD_Ready,
    input  logic [RF_IDX_W-1:0] iLD_Addr,
    input  logic [DATA_W-1:0]   iLD_Data,
    input  logic                iCM_Valid,
    output logic                oCM_Ready,
    input  logic [RF_IDX_W-1:0] iCM_Addr,
    input  logic [DATA_W-1:0]   iCM_Data,
    output logic                oWB_RF_Writeback_Enable,
    output logic [RF_IDX_W-1:0] oWB_RF_Write_Addr,
    output logic [DATA_W-1:0]   oWB_RF_Write_Data,
    output logic [1:0]          oWB_Grant_Src
`ifdef PE_WB_ARB_STATS_EN
    ,
    output logic [15:0]         oArb_Conflict_Count
`endif
);

    localparam logic [1:0] SRC_EX   = 2'b00;
    localparam logic [1:0] SRC_LD   = 2'b01;
    localparam logic [1:0] SRC_CM   = 2'b10;
    localparam logic [1:0] SRC_NONE = 2'b11;
    localparam logic [7:0] STARVE_LIMIT_C = 8'(STARVE_LIMIT);

    // ST_STALL lasts exactly one cycle: the EX bubble forced by the starve counter
    typedef enum logic {ST_RUN, ST_STALL} state_t;

    state_t                state_q, state_d;
    logic                  rr_ld_q, rr_ld_d;      // 1: LD wins the next LD/CM tie
    logic [7:0]            starve_q, starve_d;
    logic                  wb_en_q, wb_en_d;
    logic [RF_IDX_W-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic [1:0]            wb_src_q, wb_src_d;

    logic                  ex_req;
    logic                  sec_pending;
    logic [7:0]            starve_inc;
    logic [1:0]            grant_src;

    // State registers for the stall FSM, round-robin pointer and starve counter
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state_q  <= ST_RUN;
            rr_ld_q  <= 1'b1;
            starve_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            rr_ld_q  <= rr_ld_d;
            starve_q <= starve_d;
        end
    end

    // Grant selection plus next-state for stall FSM, pointer and starve counter
    always_comb begin
        grant_src   = SRC_NONE;
        state_d     = ST_RUN;
        rr_ld_d     = rr_ld_q;
        starve_d    = 8'd0;
        ex_req      = iEX_Write_RF_Enable && (state_q == ST_RUN);
        sec_pending = iLD_Valid || iCM_Valid;
        starve_inc  = starve_q + 8'd1;

        // Nothing is granted while reset is held so Ready drops at once
        if (iReset) begin
            if (ex_req) begin
                grant_src = SRC_EX;
            end else if (iLD_Valid && (!iCM_Valid || rr_ld_q)) begin
                grant_src = SRC_LD;
            end else if (iCM_Valid) begin
                grant_src = SRC_CM;
            end
        end

        case (grant_src)
            SRC_EX: begin
                if (sec_pending) begin
                    if (starve_inc == STARVE_LIMIT_C) begin
                        state_d  = ST_STALL;
                        starve_d = 8'd0;
                    end else begin
                        starve_d = starve_inc;
                    end
                end
            end
            SRC_LD:  rr_ld_d = 1'b0;
            SRC_CM:  rr_ld_d = 1'b1;
            default: rr_ld_d = rr_ld_q;
        endcase
    end

    // Next-state of the write-port registers: address/data hold when idle
    always_comb begin
        wb_en_d   = (grant_src != SRC_NONE);
        wb_src_d  = grant_src;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        case (grant_src)
            SRC_EX: begin
                wb_addr_d = iEX_Write_RF_Address;
                wb_data_d = iEX_Write_RF_Data;
            end
            SRC_LD: begin
                wb_addr_d = iLD_Addr;
                wb_data_d = iLD_Data;
            end
            SRC_CM: begin
                wb_addr_d = iCM_Addr;
                wb_data_d = iCM_Data;
            end
            default: ;
        endcase
    end

    // Registered RF write port; reset discards any in-flight write
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_src_q  <= SRC_NONE;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_src_q  <= wb_src_d;
        end
    end

    assign oEX_Stall               = (state_q == ST_STALL);
    assign oLD_Ready               = (grant_src == SRC_LD);
    assign oCM_Ready               = (grant_src == SRC_CM);
    assign oWB_RF_Writeback_Enable = wb_en_q;
    assign oWB_RF_Write_Addr       = wb_addr_q;
    assign oWB_RF_Write_Data       = wb_data_q;
    assign oWB_Grant_Src           = wb_src_q;

`ifdef PE_WB_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic [1:0]  n_req;

    // A conflict cycle has at least two live requests, so one must lose
    always_comb begin
        n_req          = {1'b0, ex_req} + {1'b0, iLD_Valid} + {1'b0, iCM_Valid};
        conflict_cnt_d = conflict_cnt_q;
        if (iReset && (n_req >= 2'd2) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // Saturating conflict counter register
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            conflict_cnt_q <= 16'd0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign oArb_Conflict_Count = conflict_cnt_q;
`endif

endmodule

// File: doc/pe_wb_arbiter.md
Name: pe_wb_arbiter

Overview:
- Write-port arbiter for the PE register file. It sits between three write sources and the single RF write port: the EX pipeline result, the load-return path (LSU) and the neighbour-communication unit (COM).
- EX has priority. LSU and COM share the leftover cycles round-robin.
- A starvation counter forces a one-cycle EX bubble so that secondary sources always make progress.
- RF write outputs are registered, one cycle after grant, in the same format as the WB-stage outputs.

Parameters:
- DATA_W, 32, RF write data width
- RF_IDX_W, 5, RF index width
- STARVE_LIMIT, 4, consecutive EX grants tolerated while a secondary request is pending; legal range 1..255

Ports:
- iClk  in  1  system clock, posedge
- iReset  in  1  asynchronous reset, active-low
- iEX_Write_RF_Enable  in  1  EX result write request
- iEX_Write_RF_Address  in  RF_IDX_W  EX destination index
- iEX_Write_RF_Data  in  DATA_W  EX result
- oEX_Stall  out  1  one-cycle pipeline-freeze request to EX
- iLD_Valid  in  1  load-return write request
- oLD_Ready  out  1  load write accepted this cycle
- iLD_Addr  in  RF_IDX_W  load destination index
- iLD_Data  in  DATA_W  load data
- iCM_Valid  in  1  COM write request
- oCM_Ready  out  1  COM write accepted this cycle
- iCM_Addr  in  RF_IDX_W  COM destination index
- iCM_Data  in  DATA_W  COM data
- oWB_RF_Writeback_Enable  out  1  RF write enable (registered)
- oWB_RF_Write_Addr  out  RF_IDX_W  RF write index (registered)
- oWB_RF_Write_Data  out  DATA_W  RF write data (registered)
- oWB_Grant_Src  out  2  source of the current write: 00 EX, 01 LD, 10 CM, 11 none (registered)

Behaviour:
- Reset (iReset=0, asynchronous): all outputs 0 except oWB_Grant_Src=11. RR pointer favours LD. Starve counter 0. oEX_Stall 0.
- Per-cycle grant, combinational:
  - If oEX_Stall=0 and iEX_Write_RF_Enable=1, grant EX.
  - Otherwise, if LD and/or CM is valid, grant by round-robin. When both are valid, the source not served last wins; the pointer updates only on an LD/CM grant.
  - Otherwise no grant.
- oLD_Ready/oCM_Ready are high only when that source is granted. They are combinational from the valids, the EX enable and the internal state.
- Requester contract: the requester holds Valid, Addr and Data stable until Ready. A transfer occurs on Valid&Ready. The arbiter never drops a request.
- Latency: the winner's address and data appear on oWB_RF_* at the next posedge, with Enable=1 and Grant_Src set. With no grant: Enable=0, Grant_Src=11, addr/data registers hold their previous values.
- While oEX_Stall=1, iEX_Write_RF_Enable is ignored. The EX pipeline must freeze and re-present the same write the following cycle.
- Starve counter (8-bit):
  - Increments in a cycle where EX is granted and (iLD_Valid|iCM_Valid)=1.
  - Clears when LD or CM is granted, or when neither is valid.
  - When an increment reaches STARVE_LIMIT: oEX_Stall=1 for exactly the next cycle and the counter clears. During that stall cycle the pending secondary is granted.
- Stall never lasts more than one consecutive cycle. The counter does not count during a stall cycle.
- No hazard or merging checks. Writes to the same index from different sources are committed in grant order.
- Reset asserted mid-operation: the in-flight registered write is discarded (Enable=0). Ready outputs drop immediately.

Optional Feature:
- PE_WB_ARB_STATS_EN defined:
  - Adds output oArb_Conflict_Count (16 bits).
  - Counts cycles in which at least one request is not granted (two or more of: EX enable with stall=0, LD valid, CM valid).
  - Saturates at 0xFFFF. Reset to 0.
- Not defined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset mid-traffic: LD valid with a write in flight, assert iReset=0 -> outputs immediately 0, Grant_Src=11. After release, first grant is LD.
- EX only, addr 3, data 0xDEADBEEF for one cycle -> next cycle Enable=1, Addr=3, Data=0xDEADBEEF, Grant_Src=00. Following cycle Enable=0, addr/data held.
- LD (addr 5, 0x11) and CM (addr 6, 0x22) valid together, EX idle, held until Ready -> LD written first, CM the next cycle. oLD_Ready and oCM_Ready are never high in the same cycle.
- EX enabled every cycle, LD valid, STARVE_LIMIT=4 -> four EX writes, then oEX_Stall=1 for one cycle and LD is written. The held EX write follows, with no EX data lost.
- EX idle, LD and CM continuously valid for 6 cycles -> alternation LD, CM, LD, CM, LD, CM. Starve counter and stall stay 0.
- With PE_WB_ARB_STATS_EN: 3 cycles of EX+LD contention -> oArb_Conflict_Count=3. Forced count 0xFFFF plus one more conflict -> stays 0xFFFF.
